// File: rtl/rename_table_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : rename_pkg
// Brief  : Shared rename-map types and sizing helpers.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
package rename_pkg;

   localparam int NUM_AREGS = 32;

   typedef logic [4:0] areg_t;

   function automatic int phys_addr_bits(input int num_phys_regs);
      return $clog2(num_phys_regs);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rename_table_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : complete_notif_if
// Brief  : Writeback completion notification (producer drives, rename consumes).
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
interface complete_notif_if #(
   parameter int PAB = 6
) ();
   logic           val;
   logic [PAB-1:0] preg;
   logic [PAB-1:0] ppreg;
   logic [7:0]     seq_num;
   logic [4:0]     waddr;
   logic [31:0]    wdata;
   logic           wen;

   modport master (output val, preg, ppreg, seq_num, waddr, wdata, wen);
   modport slave  (input  val, preg, ppreg, seq_num, waddr, wdata, wen);
endinterface
`default_nettype wire

// File: rtl/rename_free_list.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : rename_free_list
// Brief  : Free physical-register bit vector with lowest-index allocation.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
module rename_free_list #(
   parameter int NUM_PREGS    = 36,
   parameter int PAB          = 6,
   parameter int NUM_RESERVED = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           alloc_en,
   output logic [PAB-1:0] alloc_idx,
   output logic           alloc_rdy,
   input  logic           free_en,
   input  logic [PAB-1:0] free_idx
);

   logic [NUM_PREGS-1:0] r_free;

   // A register freed this cycle only becomes visible to the encoder next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_PREGS; i++) begin
            r_free[i] <= (i >= NUM_RESERVED);
         end
      end else begin
         if (free_en) begin
            r_free[free_idx] <= 1'b1;
         end
         if (alloc_en) begin
            r_free[alloc_idx] <= 1'b0;
         end
      end
   end

   always_comb begin
      alloc_idx = '0;
      for (int i = NUM_PREGS - 1; i >= 0; i--) begin
         if (r_free[i]) begin
            alloc_idx = PAB'(i);
         end
      end
      alloc_rdy = |r_free;
   end

endmodule
`default_nettype wire

// File: rtl/rename_table.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : rename_table
// Brief  : 32-entry architectural-to-physical rename map with pending tracking.
//          Optional RENAME_TABLE_COMPLETE_BYPASS_EN: same-cycle completion
//          clears lookup_pending combinationally.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
module rename_table
   import rename_pkg::*;
#(
   parameter  int p_num_phys_regs  = 36,
   localparam int p_phys_addr_bits = phys_addr_bits(p_num_phys_regs)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  areg_t                       alloc_areg,
   output logic [p_phys_addr_bits-1:0] alloc_preg,
   output logic [p_phys_addr_bits-1:0] alloc_ppreg,
   input  logic                        alloc_en,
   output logic                        alloc_rdy,
   input  areg_t                       lookup_areg    [2],
   output logic [p_phys_addr_bits-1:0] lookup_preg    [2],
   output logic                        lookup_pending [2],
   input  logic                        lookup_en      [2],
   complete_notif_if.slave             complete
);

   logic [p_phys_addr_bits-1:0] r_map [NUM_AREGS];
   logic [p_num_phys_regs-1:0]  r_pending;

   logic [p_phys_addr_bits-1:0] w_fl_idx;
   logic                        w_fl_rdy;
   logic                        w_x0;
   logic                        w_alloc_fire;
   logic                        w_free_en;
   logic                        w_unused;

   // x0 is hardwired to preg 0 and never consumes a free register.
   assign w_x0         = (alloc_areg == '0);
   assign alloc_rdy    = w_x0 | w_fl_rdy;
   assign alloc_preg   = w_x0 ? '0 : w_fl_idx;
   assign alloc_ppreg  = r_map[alloc_areg];
   assign w_alloc_fire = alloc_en & ~w_x0 & w_fl_rdy;
   assign w_free_en    = complete.val & (complete.ppreg != '0);
   assign w_unused     = ^{complete.seq_num, complete.waddr, complete.wdata,
                           complete.wen, lookup_en[0], lookup_en[1]};

   rename_free_list #(
      .NUM_PREGS    (p_num_phys_regs),
      .PAB          (p_phys_addr_bits),
      .NUM_RESERVED (NUM_AREGS)
   ) u_free_list (
      .clk       (clk),
      .rst       (rst),
      .alloc_en  (w_alloc_fire),
      .alloc_idx (w_fl_idx),
      .alloc_rdy (w_fl_rdy),
      .free_en   (w_free_en),
      .free_idx  (complete.ppreg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_AREGS; i++) begin
            r_map[i] <= p_phys_addr_bits'(i);
         end
         r_pending <= '0;
      end else begin
         if (complete.val) begin
            r_pending[complete.preg] <= 1'b0;
         end
         if (w_alloc_fire) begin
            r_map[alloc_areg]   <= w_fl_idx;
            r_pending[w_fl_idx] <= 1'b1;
         end
      end
   end

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         lookup_preg[p]    = r_map[lookup_areg[p]];
         lookup_pending[p] = (lookup_areg[p] != '0) && r_pending[r_map[lookup_areg[p]]];
`ifdef RENAME_TABLE_COMPLETE_BYPASS_EN
         if (complete.val && (complete.preg == r_map[lookup_areg[p]])) begin
            lookup_pending[p] = 1'b0;
         end
`endif
      end
   end

   function automatic string trace();
      return $sformatf("A[%s a%0d p%0d pp%0d] L0[a%0d p%0d %0d] L1[a%0d p%0d %0d] C[%s p%0d pp%0d]",
                       (alloc_en && alloc_rdy) ? "*" : " ", alloc_areg, alloc_preg, alloc_ppreg,
                       lookup_areg[0], lookup_preg[0], lookup_pending[0],
                       lookup_areg[1], lookup_preg[1], lookup_pending[1],
                       complete.val ? "*" : " ", complete.preg, complete.ppreg);
   endfunction

endmodule
`default_nettype wire

// File: tb/tb_rename_table.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_rename_table
// Brief  : Directed and random checks of rename_table against a queue-based model.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_rename_table;
   import rename_pkg::*;

   parameter  int N   = 36;
   localparam int PAB = $clog2(N);

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   areg_t          alloc_areg;
   logic [PAB-1:0] alloc_preg;
   logic [PAB-1:0] alloc_ppreg;
   logic           alloc_en;
   logic           alloc_rdy;
   areg_t          lookup_areg    [2];
   logic [PAB-1:0] lookup_preg    [2];
   logic           lookup_pending [2];
   logic           lookup_en      [2];

   complete_notif_if #(.PAB(PAB)) cif ();

   rename_table #(.p_num_phys_regs(N)) dut (
      .clk            (clk),
      .rst            (rst),
      .alloc_areg     (alloc_areg),
      .alloc_preg     (alloc_preg),
      .alloc_ppreg    (alloc_ppreg),
      .alloc_en       (alloc_en),
      .alloc_rdy      (alloc_rdy),
      .lookup_areg    (lookup_areg),
      .lookup_preg    (lookup_preg),
      .lookup_pending (lookup_pending),
      .lookup_en      (lookup_en),
      .complete       (cif)
   );

   always #5 clk = ~clk;

   typedef struct { int preg; int ppreg; } inflight_t;

   int        checks = 0;
   int        errors = 0;
   int        mmap [32];
   bit        mpend [N];
   int        freeq [$];
   inflight_t infl [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mmap[i] = i;
      for (int i = 0; i < N; i++) mpend[i] = 1'b0;
      freeq.delete();
      for (int i = 32; i < N; i++) freeq.push_back(i);
      infl.delete();
   endtask

   // Effects of one clock edge, from the inputs presented during that cycle.
   task automatic model_update();
      int ap;
      ap = -1;
      if (alloc_en && alloc_areg != 0 && freeq.size() > 0) begin
         ap = freeq.pop_front();
         infl.push_back('{preg: ap, ppreg: mmap[alloc_areg]});
      end
      if (cif.val) begin
         mpend[cif.preg] = 1'b0;
         if (cif.ppreg != 0) begin
            freeq.push_back(int'(cif.ppreg));
            freeq.sort();
         end
      end
      if (ap >= 0) begin
         mmap[alloc_areg] = ap;
         mpend[ap]        = 1'b1;
      end
   endtask

   function automatic int exp_pend(input areg_t a);
      if (a == 0) return 0;
`ifdef RENAME_TABLE_COMPLETE_BYPASS_EN
      if (cif.val && int'(cif.preg) == mmap[a]) return 0;
`endif
      return int'(mpend[mmap[a]]);
   endfunction

   task automatic check_comb(input string ctx);
      #1;
      chk({ctx, ".rdy"}, alloc_rdy, (alloc_areg == 0 || freeq.size() > 0) ? 1 : 0);
      if (alloc_areg == 0) chk({ctx, ".preg"}, alloc_preg, 0);
      else if (freeq.size() > 0) chk({ctx, ".preg"}, alloc_preg, freeq[0]);
      chk({ctx, ".ppreg"}, alloc_ppreg, mmap[alloc_areg]);
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("%s.lpreg%0d", ctx, p), lookup_preg[p], mmap[lookup_areg[p]]);
         chk($sformatf("%s.lpend%0d", ctx, p), lookup_pending[p], exp_pend(lookup_areg[p]));
      end
   endtask

   task automatic step(input string ctx);
      check_comb(ctx);
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic set_alloc(input int a, input bit en);
      alloc_areg = areg_t'(a);
      alloc_en   = en;
   endtask

   task automatic set_comp(input bit v, input int p, input int pp);
      cif.val   = v;
      cif.preg  = PAB'(p);
      cif.ppreg = PAB'(pp);
   endtask

   task automatic set_look(input int a0, input int a1);
      lookup_areg[0] = areg_t'(a0);
      lookup_areg[1] = areg_t'(a1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_alloc(0, 1'b0);
      set_comp(1'b0, 0, 0);
      set_look(0, 0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int cnt;
      cif.seq_num  = '0;
      cif.waddr    = '0;
      cif.wdata    = '0;
      cif.wen      = 1'b0;
      lookup_en[0] = 1'b1;
      lookup_en[1] = 1'b1;

      // Initial identity map
      do_reset();
      #1;
      chk("reset.rdy", alloc_rdy, 1);
      for (int i = 0; i < 32; i++) begin
         set_look(i, i);
         #1;
         chk("init.preg", lookup_preg[0], i);
         chk("init.pend", lookup_pending[1], 0);
         step("init");
      end

      // Basic allocation
      do_reset();
      set_alloc(1, 1'b1);
      set_look(1, 1);
      #1;
      chk("basic.preg", alloc_preg, 32);
      chk("basic.ppreg", alloc_ppreg, 1);
      step("basic0");
      set_alloc(0, 1'b0);
      #1;
      chk("basic.l0", lookup_preg[0], 32);
      chk("basic.l1pend", lookup_pending[1], 1);
      step("basic1");

      // x0 is never renamed
      set_alloc(0, 1'b1);
      set_look(0, 1);
      #1;
      chk("x0.preg", alloc_preg, 0);
      chk("x0.rdy", alloc_rdy, 1);
      step("x0a");
      set_alloc(0, 1'b0);
      step("x0b");

      // Capacity: drain the free list
      do_reset();
      cnt = (N - 32 < 31) ? N - 32 : 31;
      for (int i = 1; i <= cnt; i++) begin
         set_alloc(i, 1'b1);
         set_look(i - 1, i);
         #1;
         chk("cap.preg", alloc_preg, 31 + i);
         chk("cap.ppreg", alloc_ppreg, i);
         step("cap_a");
         set_alloc(0, 1'b0);
         #1;
         chk("cap.lpreg", lookup_preg[1], 31 + i);
         chk("cap.lpend", lookup_pending[1], 1);
         step("cap_l");
      end
      if (N - 32 <= 31) begin
         set_alloc(cnt, 1'b1);
         set_look(cnt, 0);
         #1;
         chk("cap.empty_rdy", alloc_rdy, 0);
         step("cap_e");
         set_alloc(0, 1'b0);
         #1;
         chk("cap.noeffect", lookup_preg[0], 31 + cnt);
         step("cap_n");
      end

      // Reuse: a freed register is not allocatable in the cycle it is freed
      do_reset();
      set_alloc(1, 1'b1);
      set_look(1, 2);
      step("reuse0");
      set_alloc(2, 1'b1);
      set_comp(1'b1, 32, 1);
      #1;
      chk("reuse.same_cycle", alloc_preg, 33);
      step("reuse1");
      set_alloc(1, 1'b1);
      set_comp(1'b0, 0, 0);
      #1;
      chk("reuse.preg", alloc_preg, 1);
      chk("reuse.ppreg", alloc_ppreg, 32);
      step("reuse2");
      set_alloc(0, 1'b0);
      step("reuse3");

      // Pending clear, with optional same-cycle bypass
      do_reset();
      set_alloc(3, 1'b1);
      set_look(3, 3);
      step("pclr0");
      set_alloc(0, 1'b0);
      set_comp(1'b1, 32, 3);
      #1;
`ifdef RENAME_TABLE_COMPLETE_BYPASS_EN
      chk("pclr.bypass", lookup_pending[0], 0);
`else
      chk("pclr.nobypass", lookup_pending[0], 1);
`endif
      step("pclr1");
      set_comp(1'b0, 0, 0);
      #1;
      chk("pclr.preg", lookup_preg[0], 32);
      chk("pclr.pend", lookup_pending[1], 0);
      step("pclr2");

      // Random traffic against the model
      do_reset();
      for (int c = 0; c < 600; c++) begin
         set_alloc(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 31),
                   $urandom_range(0, 9) < 7);
         set_look($urandom_range(0, 31), $urandom_range(0, 31));
         if (infl.size() > 0 && $urandom_range(0, 9) < 4) begin
            int k;
            k = $urandom_range(0, infl.size() - 1);
            set_comp(1'b1, infl[k].preg, infl[k].ppreg);
            infl.delete(k);
         end else begin
            set_comp(1'b0, 0, 0);
         end
         step("rand");
      end

      // Reset mid-operation restores identity
      rst = 1'b1;
      set_alloc(0, 1'b0);
      set_comp(1'b0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      set_look(7, 31);
      #1;
      chk("midrst.l0", lookup_preg[0], 7);
      chk("midrst.l1", lookup_preg[1], 31);
      step("midrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
